// File: rtl/memory_5x8.sv
// 32-word x 8-bit single-port synchronous RAM on a shared tri-state data bus.
// Writes take the bus value. Reads load a holding register that drives the bus when granted.
module memory_5x8 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  ld_ir,
  input  logic                  data_e,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data_out
);

  localparam int Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drive_en;

  // Write wins over any read strobe, so the memory never fights the external writer.
  assign wr_en    = sel & wr;
  assign rd_en    = sel & ~wr & (rd | ld_ir);
  assign drive_en = ~rst & rd_en & data_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[address] <= data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[address];
    end
  end

  assign data_out = drive_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_memory_5x8.sv
// Directed bench for memory_5x8. Release of the bus is checked by driving a probe value of 0;
// any memory drive of a nonzero rdata would corrupt it.
module tb_memory_5x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       data_e;
  logic [4:0] address;
  logic       probe_en;
  logic [7:0] probe_val;
  wire  [7:0] bus;

  int n_checks = 0;
  int n_fail   = 0;

  assign bus = probe_en ? probe_val : 8'hzz;

  always #5 clk = ~clk;

  memory_5x8 #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .ld_ir   (ld_ir),
    .data_e  (data_e),
    .address (address),
    .data_out(bus)
  );

  task automatic idle();
    sel = 1'b0; rd = 1'b0; wr = 1'b0; ld_ir = 1'b0; data_e = 1'b0;
    probe_en = 1'b0; probe_val = 8'h00;
  endtask

  // Called at a negedge; leaves the bus released at the following negedge.
  task automatic do_write(input logic [4:0] a, input logic [7:0] v);
    sel = 1'b1; wr = 1'b1; rd = 1'b0; ld_ir = 1'b0; data_e = 1'b1;
    address = a; probe_en = 1'b1; probe_val = v;
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  // Called at a negedge; read strobes stay asserted so the bus can be sampled afterwards.
  task automatic do_read(input logic [4:0] a);
    sel = 1'b1; wr = 1'b0; rd = 1'b1; ld_ir = 1'b0; data_e = 1'b1;
    address = a; probe_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    address = 5'd0;
    rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;
    do_read(5'd5);
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL reset_read: got %h expected %h", bus, 8'h00); n_fail++;
    end
    idle();
  endtask

  task automatic test_write_read();
    do_write(5'd5, 8'hA5);
    do_read(5'd5);
    n_checks++;
    if (bus !== 8'hA5) begin
      $display("FAIL write_read: got %h expected %h", bus, 8'hA5); n_fail++;
    end
    idle();
  endtask

  task automatic test_address_independence();
    do_write(5'd0, 8'h3C);
    do_write(5'd31, 8'hC3);
    do_read(5'd0);
    n_checks++;
    if (bus !== 8'h3C) begin
      $display("FAIL addr0: got %h expected %h", bus, 8'h3C); n_fail++;
    end
    do_read(5'd31);
    n_checks++;
    if (bus !== 8'hC3) begin
      $display("FAIL addr31: got %h expected %h", bus, 8'hC3); n_fail++;
    end
    do_read(5'd5);
    n_checks++;
    if (bus !== 8'hA5) begin
      $display("FAIL addr5: got %h expected %h", bus, 8'hA5); n_fail++;
    end
    idle();
  endtask

  task automatic test_gating();
    // sel low: write must be ignored
    sel = 1'b0; wr = 1'b1; data_e = 1'b1; address = 5'd5;
    probe_en = 1'b1; probe_val = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    idle();
    do_read(5'd5);
    n_checks++;
    if (bus !== 8'hA5) begin
      $display("FAIL sel_gates_write: got %h expected %h", bus, 8'hA5); n_fail++;
    end
    // data_e low: rdata updates from addr 0 but bus stays released
    data_e = 1'b0; address = 5'd0; probe_en = 1'b1; probe_val = 8'h00;
    #1;
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL data_e_release: got %h expected %h", bus, 8'h00); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL data_e_release_after_edge: got %h expected %h", bus, 8'h00); n_fail++;
    end
    probe_en = 1'b0; data_e = 1'b1;
    #1;
    n_checks++;
    if (bus !== 8'h3C) begin
      $display("FAIL data_e_comb_enable: got %h expected %h", bus, 8'h3C); n_fail++;
    end
    // sel low with rd: no rdata update, bus released
    @(negedge clk);
    sel = 1'b0; address = 5'd31; probe_en = 1'b1; probe_val = 8'h00;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL sel_release: got %h expected %h", bus, 8'h00); n_fail++;
    end
    probe_en = 1'b0; sel = 1'b1;
    #1;
    n_checks++;
    if (bus !== 8'h3C) begin
      $display("FAIL sel_gates_read: got %h expected %h", bus, 8'h3C); n_fail++;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_priority();
    do_read(5'd5);  // rdata = A5, disjoint bits from 5A
    wr = 1'b1; address = 5'd7; probe_en = 1'b1; probe_val = 8'h5A;
    #1;
    n_checks++;
    if (bus !== 8'h5A) begin
      $display("FAIL wr_rd_no_drive: got %h expected %h", bus, 8'h5A); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus !== 8'h5A) begin
      $display("FAIL wr_rd_no_drive_after_edge: got %h expected %h", bus, 8'h5A); n_fail++;
    end
    idle();
    do_read(5'd7);
    n_checks++;
    if (bus !== 8'h5A) begin
      $display("FAIL wr_wins_stored: got %h expected %h", bus, 8'h5A); n_fail++;
    end
    do_read(5'd0);
    idle();
    sel = 1'b1; ld_ir = 1'b1; data_e = 1'b1; address = 5'd7;
    #1;
    n_checks++;
    if (bus !== 8'h3C) begin
      $display("FAIL ld_ir_prev_rdata: got %h expected %h", bus, 8'h3C); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus !== 8'h5A) begin
      $display("FAIL ld_ir_read: got %h expected %h", bus, 8'h5A); n_fail++;
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 8'hA5);
    do_read(5'd5);
    n_checks++;
    if (bus !== 8'hA5) begin
      $display("FAIL pre_reset_read: got %h expected %h", bus, 8'hA5); n_fail++;
    end
    #1;
    rst = 1'b1;
    probe_en = 1'b1; probe_val = 8'h00;
    #1;
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL async_reset_release: got %h expected %h", bus, 8'h00); n_fail++;
    end
    #1;
    rst = 1'b0;
    probe_en = 1'b0;
    @(negedge clk);
    do_read(5'd5);
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL async_reset_cleared: got %h expected %h", bus, 8'h00); n_fail++;
    end
    do_read(5'd7);
    n_checks++;
    if (bus !== 8'h00) begin
      $display("FAIL async_reset_cleared7: got %h expected %h", bus, 8'h00); n_fail++;
    end
    idle();
  endtask

  initial begin
    address = 5'd0;
    rst = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_address_independence();
    test_gating();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_5x8.md
# memory_5x8

Single-port 32-word x 8-bit synchronous RAM with a shared bidirectional data bus, used as the main memory of the simple CPU datapath. Writes and reads are clocked on the rising edge. Read data is held in an output register and driven onto the tri-state bus only when the bus is granted to the memory. The `ld_ir` strobe gives the controller an instruction-fetch read path that behaves like `rd`.

## Interface
- `DATA_WIDTH`, default 8: word width and bus width.
- `ADDR_WIDTH`, default 5: address width; depth is 2**ADDR_WIDTH (32 words).

Ports:
- `clk`, input, 1: single clock, rising-edge active.
- `rst`, input, 1: reset, asynchronous and active-high.
- `sel`, input, 1: chip select; no access occurs while low.
- `rd`, input, 1: read request.
- `wr`, input, 1: write request.
- `ld_ir`, input, 1: instruction-fetch read request, equivalent to `rd`.
- `data_e`, input, 1: bus output enable for read data.
- `address`, input, ADDR_WIDTH: word address.
- `data_out`, inout, DATA_WIDTH: shared bidirectional data bus.

## Operation
- Storage: array `mem[0..2**ADDR_WIDTH-1]` of DATA_WIDTH bits. Read register `rdata` is DATA_WIDTH bits.
- Reset (`rst`=1, asynchronous): every `mem` word = 0 and `rdata` = 0. The bus is released to Z while `rst`=1.
- Write: on a rising edge with `sel`=1 and `wr`=1, `mem[address]` <= `data_out`, which is the value driven externally on the bus. `data_e` does not gate writes.
- Read: on a rising edge with `sel`=1, `wr`=0 and (`rd`=1 or `ld_ir`=1), `rdata` <= `mem[address]`. Otherwise `rdata` holds its value.
- Bus drive (combinational): `data_out` = `rdata` when `rst`=0, `sel`=1, `wr`=0, (`rd` or `ld_ir`)=1 and `data_e`=1. Otherwise `data_out` = all Z.
- Simultaneous `wr` and `rd`/`ld_ir`: the write wins. `rdata` is not updated and the bus is not driven, so the memory never contends with the external writer.
- `sel`=0: no write, no `rdata` update, bus Z, regardless of the other strobes.
- Address is used as given. Every 5-bit value is a valid word, so there is no out-of-range case.

## Timing
- Write latency: the value is stored at the edge where `sel`&`wr` is sampled. A read of that address issued in the next cycle returns the new value.
- Read latency: 1 cycle. `rd` or `ld_ir` is sampled at edge N. `rdata` holds `mem[address]` after edge N and appears on the bus after edge N if drive conditions hold.
- Before edge N, if drive conditions already hold, the bus shows the previous `rdata`, which is 0 after reset.
- Bus enable and release are combinational from `sel`/`rd`/`ld_ir`/`wr`/`data_e` within the same cycle. There are no turnaround cycles; the external master must release the bus in the cycle it deasserts `wr`.
- Reset asserted mid-operation: memory and `rdata` clear immediately and the bus goes Z, without waiting for a clock edge. The first access is accepted at the first rising edge with `rst`=0.
- Outputs at reset: `data_out` = Z, internal `rdata` = 0.

## Test plan
- Reset then read: `rst` high 20 ns, then `sel`=1, `rd`=1, `data_e`=1, address 5'd5. After one edge the bus reads 8'h00.
- Write/read: write 8'hA5 to 5'b00101 (`sel`=`wr`=`data_e`=1, external driver on) for one edge. Release the driver, set `rd`=1, `wr`=0. After one edge `data_out` = 8'hA5.
- Address independence: write 8'h3C to 5'd0 and 8'hC3 to 5'd31. Read both back correctly. Read 5'd5, which returns 8'hA5 (written earlier) or 8'h00 (after reset).
- Gating: with `sel`=0 and `wr`=1, drive 8'hFF to address 5 and then read; the old value is kept. With `data_e`=0 and `rd`=1, the bus is Z.
- Priority: `wr`=`rd`=1 with bus driven 8'h5A to address 7. The memory does not drive the bus, and a later read returns 8'h5A. Also, `ld_ir`=1 alone returns `mem[7]` = 8'h5A.
- Async reset: after writing 8'hA5 to address 5, pulse `rst` between clock edges. The bus goes Z at once, and a following read of address 5 returns 8'h00.
